// File: rtl/lsu_pkg.sv
// Shared core definitions for the load/store unit: funct3 encodings, FSM state
// type and the data-bus request payload.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    // RV32 load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32 store funct3 encodings
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Access size taken from funct3[1:0]
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [0:0] {
        LSU_IDLE      = 1'b0,
        LSU_WAIT_DATA = 1'b1
    } lsu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] address;
        logic [BE_W-1:0] byteenable;
        logic [XLEN-1:0] writedata;
    } dbus_req_t;

endpackage

// File: rtl/lsu_load_format.sv
// Combinational load-data extraction: shifts the bus word down to the accessed
// byte lane and sign- or zero-extends according to funct3.
module lsu_load_format
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'h000000, shifted[7:0]};
            F3_LHU:  data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit driving a waitrequest/readdatavalid data bus.
// Optional macro LSU_MISALIGN_CHECK_EN enables misaligned-access trapping.
module lsu
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,

    input  logic            mem_valid,
    input  logic            mem_mem_read,
    input  logic            mem_mem_write,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_address,
    input  logic [XLEN-1:0] mem_wdata,

    output logic            dbus_read,
    output logic            dbus_write,
    output logic [XLEN-1:0] dbus_address,
    output logic [BE_W-1:0] dbus_byteenable,
    output logic [XLEN-1:0] dbus_writedata,
    input  logic [XLEN-1:0] dbus_readdata,
    input  logic            dbus_waitrequest,
    input  logic            dbus_readdatavalid,

    output logic [XLEN-1:0] lsu_readdata,
    output logic            lsu_dbus_busy,
    output logic            lsu_load_misaligned,
    output logic            lsu_store_misaligned
);

    lsu_state_t      state_q;
    lsu_state_t      state_d;
    logic [1:0]      size;
    logic            misaligned;
    logic            is_load;
    logic            is_store;
    logic            rd_req;
    logic            wr_req;
    dbus_req_t       req;
    logic [XLEN-1:0] fmt_data;

    assign size = mem_funct3[1:0];

    // A simultaneous read and write is treated as a load
    assign is_load  = mem_valid & mem_mem_read;
    assign is_store = mem_valid & mem_mem_write & ~mem_mem_read;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (size == SIZE_H) begin
            misaligned = mem_address[0];
        end else if (size != SIZE_B) begin
            misaligned = (mem_address[1:0] != 2'b00);
        end
    end

    assign lsu_load_misaligned  = (state_q == LSU_IDLE) & is_load & misaligned;
    assign lsu_store_misaligned = (state_q == LSU_IDLE) & is_store & misaligned;
`else
    assign misaligned           = 1'b0;
    assign lsu_load_misaligned  = 1'b0;
    assign lsu_store_misaligned = 1'b0;
`endif

    assign rd_req = (state_q == LSU_IDLE) & is_load & ~misaligned;
    assign wr_req = (state_q == LSU_IDLE) & is_store & ~misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus request payload and stall request
    always_comb begin
        state_d       = state_q;
        req           = '0;
        dbus_read     = 1'b0;
        dbus_write    = 1'b0;
        lsu_dbus_busy = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (rd_req || wr_req) begin
                    req.address = {mem_address[XLEN-1:2], 2'b00};
                    case (size)
                        SIZE_B:  req.byteenable = 4'(4'b0001 << mem_address[1:0]);
                        SIZE_H:  req.byteenable = 4'(4'b0011 << mem_address[1:0]);
                        default: req.byteenable = 4'b1111;
                    endcase
                end
                if (rd_req) begin
                    dbus_read     = 1'b1;
                    lsu_dbus_busy = 1'b1;
                    if (!dbus_waitrequest) begin
                        state_d = LSU_WAIT_DATA;
                    end
                end else if (wr_req) begin
                    dbus_write    = 1'b1;
                    lsu_dbus_busy = dbus_waitrequest;
                    case (size)
                        SIZE_B:  req.writedata = {4{mem_wdata[7:0]}};
                        SIZE_H:  req.writedata = {2{mem_wdata[15:0]}};
                        default: req.writedata = mem_wdata;
                    endcase
                end
            end
            LSU_WAIT_DATA: begin
                // An accepted load always waits for its beat, even if flushed
                lsu_dbus_busy = ~dbus_readdatavalid;
                if (dbus_readdatavalid) begin
                    state_d = LSU_IDLE;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    assign dbus_address    = req.address;
    assign dbus_byteenable = req.byteenable;
    assign dbus_writedata  = req.writedata;

    lsu_load_format u_load_format (
        .rdata   (dbus_readdata),
        .addr_lo (mem_address[1:0]),
        .funct3  (mem_funct3),
        .data    (fmt_data)
    );

    assign lsu_readdata = ((state_q == LSU_WAIT_DATA) && dbus_readdatavalid) ? fmt_data : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; covers the default build and, when
// LSU_MISALIGN_CHECK_EN is defined, the misaligned-access trap.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_address;
    logic [3:0]  dbus_byteenable;
    logic [31:0] dbus_writedata;
    logic [31:0] dbus_readdata;
    logic        dbus_waitrequest;
    logic        dbus_readdatavalid;
    logic [31:0] lsu_readdata;
    logic        lsu_dbus_busy;
    logic        lsu_load_misaligned;
    logic        lsu_store_misaligned;

    int n_assert;
    int n_fail;

    lsu dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_valid            (mem_valid),
        .mem_mem_read         (mem_mem_read),
        .mem_mem_write        (mem_mem_write),
        .mem_funct3           (mem_funct3),
        .mem_address          (mem_address),
        .mem_wdata            (mem_wdata),
        .dbus_read            (dbus_read),
        .dbus_write           (dbus_write),
        .dbus_address         (dbus_address),
        .dbus_byteenable      (dbus_byteenable),
        .dbus_writedata       (dbus_writedata),
        .dbus_readdata        (dbus_readdata),
        .dbus_waitrequest     (dbus_waitrequest),
        .dbus_readdatavalid   (dbus_readdatavalid),
        .lsu_readdata         (lsu_readdata),
        .lsu_dbus_busy        (lsu_dbus_busy),
        .lsu_load_misaligned  (lsu_load_misaligned),
        .lsu_store_misaligned (lsu_store_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        mem_valid     = v;
        mem_mem_read  = rd;
        mem_mem_write = wr;
        mem_funct3    = f3;
        mem_address   = a;
        mem_wdata     = wd;
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_read"},  32'(dbus_read), 32'd0);
        chk({tag, "_write"}, 32'(dbus_write), 32'd0);
        chk({tag, "_addr"},  dbus_address, 32'd0);
        chk({tag, "_be"},    32'(dbus_byteenable), 32'd0);
    endtask

    initial begin
        n_assert           = 0;
        n_fail             = 0;
        rst                = 1'b1;
        dbus_readdata      = 32'd0;
        dbus_waitrequest   = 1'b0;
        dbus_readdatavalid = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

        // Reset state: every output low
        #3;
        chk_bus_idle("rst");
        chk("rst_wd",    dbus_writedata, 32'd0);
        chk("rst_rdata", lsu_readdata, 32'd0);
        chk("rst_busy",  32'(lsu_dbus_busy), 32'd0);
        chk("rst_lmis",  32'(lsu_load_misaligned), 32'd0);
        chk("rst_smis",  32'(lsu_store_misaligned), 32'd0);
        step();
        rst = 1'b0;

        // SW 0x100 <- 0xDEADBEEF, no wait: single cycle
        step();
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        #1;
        chk("sw_write", 32'(dbus_write), 32'd1);
        chk("sw_read",  32'(dbus_read), 32'd0);
        chk("sw_addr",  dbus_address, 32'h100);
        chk("sw_be",    32'(dbus_byteenable), 32'hF);
        chk("sw_wd",    dbus_writedata, 32'hDEADBEEF);
        chk("sw_busy",  32'(lsu_dbus_busy), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1;
        chk_bus_idle("sw_done");
        chk("sw_done_state", 32'(dut.state_q), 32'd0);

        // SB 0x103 <- 0xA5 with two wait cycles
        step();
        dbus_waitrequest = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("sb_wait_busy",  32'(lsu_dbus_busy), 32'd1);
            chk("sb_wait_write", 32'(dbus_write), 32'd1);
            chk("sb_wait_addr",  dbus_address, 32'h100);
            chk("sb_wait_be",    32'(dbus_byteenable), 32'b1000);
            chk("sb_wait_wd",    dbus_writedata, 32'hA5A5A5A5);
            step();
        end
        dbus_waitrequest = 1'b0;
        #1;
        chk("sb_go_busy",  32'(lsu_dbus_busy), 32'd0);
        chk("sb_go_write", 32'(dbus_write), 32'd1);
        chk("sb_go_state", 32'(dut.state_q), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

        // SH 0x502 <- 0xBEEF
        step();
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h502, 32'h1234BEEF);
        #1;
        chk("sh_be", 32'(dbus_byteenable), 32'b1100);
        chk("sh_wd", dbus_writedata, 32'hBEEFBEEF);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

        // Beat while IDLE is ignored
        dbus_readdatavalid = 1'b1;
        dbus_readdata      = 32'hFFFFFFFF;
        #1;
        chk("idle_rdv_data",  lsu_readdata, 32'd0);
        chk("idle_rdv_busy",  32'(lsu_dbus_busy), 32'd0);
        step();
        chk("idle_rdv_state", 32'(dut.state_q), 32'd0);
        dbus_readdatavalid = 1'b0;

        // LB 0x202, beat arrives on the fourth cycle after accept
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h202, 32'd0);
        #1;
        chk("lb_acc_read", 32'(dbus_read), 32'd1);
        chk("lb_acc_addr", dbus_address, 32'h200);
        chk("lb_acc_be",   32'(dbus_byteenable), 32'b0100);
        chk("lb_acc_busy", 32'(lsu_dbus_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lb_wait_busy",  32'(lsu_dbus_busy), 32'd1);
            chk("lb_wait_read",  32'(dbus_read), 32'd0);
            chk("lb_wait_rdata", lsu_readdata, 32'd0);
        end
        step();
        dbus_readdata      = 32'h0080FF00;
        dbus_readdatavalid = 1'b1;
        #1;
        chk("lb_data",      lsu_readdata, 32'hFFFFFF80);
        chk("lb_data_busy", 32'(lsu_dbus_busy), 32'd0);
        mem_funct3 = 3'b100;
        #1;
        chk("lbu_data", lsu_readdata, 32'h00000080);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        dbus_readdatavalid = 1'b0;
        #1;
        chk("lb_end_state", 32'(dut.state_q), 32'd0);
        chk("lb_end_rdata", lsu_readdata, 32'd0);

        // LH at 0x206 with minimum latency, plus LHU/LW views of the same beat
        step();
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h206, 32'd0);
        #1;
        chk("lh_acc_addr", dbus_address, 32'h204);
        chk("lh_acc_be",   32'(dbus_byteenable), 32'b1100);
        step();
        dbus_readdata      = 32'h89AB5678;
        dbus_readdatavalid = 1'b1;
        #1;
        chk("lh_data", lsu_readdata, 32'hFFFF89AB);
        mem_funct3 = 3'b101;
        #1;
        chk("lhu_data", lsu_readdata, 32'h000089AB);
        mem_funct3  = 3'b010;
        mem_address = 32'h204;
        #1;
        chk("lw_data", lsu_readdata, 32'h89AB5678);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        dbus_readdatavalid = 1'b0;

        // Read and write together behave as a load
        step();
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h500, 32'h11111111);
        #1;
        chk("rw_read",  32'(dbus_read), 32'd1);
        chk("rw_write", 32'(dbus_write), 32'd0);
        chk("rw_wd",    dbus_writedata, 32'd0);
        step();
        dbus_readdata      = 32'hCAFEF00D;
        dbus_readdatavalid = 1'b1;
        #1;
        chk("rw_data", lsu_readdata, 32'hCAFEF00D);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        dbus_readdatavalid = 1'b0;

        // Misaligned halfword load and word store
        step();
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h201, 32'd0);
        #1;
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lh_mis_flag", 32'(lsu_load_misaligned), 32'd1);
        chk("lh_mis_read", 32'(dbus_read), 32'd0);
        chk("lh_mis_busy", 32'(lsu_dbus_busy), 32'd0);
        step();
        chk("lh_mis_state", 32'(dut.state_q), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h55555555);
        #1;
        chk("sw_mis_flag",  32'(lsu_store_misaligned), 32'd1);
        chk("sw_mis_write", 32'(dbus_write), 32'd0);
        chk("sw_mis_busy",  32'(lsu_dbus_busy), 32'd0);
`else
        chk("lh_mis_flag", 32'(lsu_load_misaligned), 32'd0);
        chk("lh_mis_read", 32'(dbus_read), 32'd1);
        chk("lh_mis_be",   32'(dbus_byteenable), 32'b0110);
        step();
        dbus_readdata      = 32'h00ABCD00;
        dbus_readdatavalid = 1'b1;
        #1;
        chk("lh_mis_data", lsu_readdata, 32'hFFFFABCD);
        step();
        dbus_readdatavalid = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h55555555);
        #1;
        chk("sw_mis_flag",  32'(lsu_store_misaligned), 32'd0);
        chk("sw_mis_write", 32'(dbus_write), 32'd1);
        chk("sw_mis_addr",  dbus_address, 32'h100);
        chk("sw_mis_be",    32'(dbus_byteenable), 32'hF);
`endif
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

        // Reset in WAIT_DATA, then a stale beat
        step();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
        step();
        chk("rstw_state_wait", 32'(dut.state_q), 32'd1);
        #2;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h300, 32'd0);
        #1;
        chk("rstw_state", 32'(dut.state_q), 32'd0);
        chk("rstw_busy",  32'(lsu_dbus_busy), 32'd0);
        chk_bus_idle("rstw");
        step();
        rst                = 1'b0;
        dbus_readdata      = 32'h77777777;
        dbus_readdatavalid = 1'b1;
        #1;
        chk("stale_rdata", lsu_readdata, 32'd0);
        chk("stale_busy",  32'(lsu_dbus_busy), 32'd0);
        chk("stale_state", 32'(dut.state_q), 32'd0);
        step();
        dbus_readdatavalid = 1'b0;

        // Flush while in WAIT_DATA: beat still awaited, no second request
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h400, 32'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("flush_state", 32'(dut.state_q), 32'd1);
            chk("flush_busy",  32'(lsu_dbus_busy), 32'd1);
            chk("flush_read",  32'(dbus_read), 32'd0);
            step();
        end
        dbus_readdata      = 32'h0BADC0DE;
        dbus_readdatavalid = 1'b1;
        #1;
        chk("flush_data", lsu_readdata, 32'h0BADC0DE);
        chk("flush_dbusy", 32'(lsu_dbus_busy), 32'd0);
        step();
        dbus_readdatavalid = 1'b0;
        #1;
        chk("flush_end_state", 32'(dut.state_q), 32'd0);
        chk("flush_end_read",  32'(dbus_read), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
